regfile_arbiter: RTL and testbench

Sequencer and arbiter for the single-port on-core register file. It brings the register file out of reset, then shares its one read/write port among `NUM_REQ` requesters, for example decode operand fetch, writeback and debug. Each cycle it grants at most one request, drives the register file port, and returns a registered response one cycle later. It sits between the pipeline stages and the register file and owns every register file control input.

---
 rtl/regfile_arbiter.sv | 143 ++++++++++++++
 tb/tb_regfile_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: register file init sequencer plus single-port arbiter with a 1-cycle registered response.
// Define REGFILE_ARB_RR_EN for round-robin arbitration; default build is fixed priority (lowest index wins).
module regfile_arbiter #(
  parameter int unsigned WORD_LEN    = 64,
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned INIT_CYCLES = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ-1:0]          req_write_i,
  input  logic [NUM_REQ*4-1:0]        req_reg_i,
  input  logic [NUM_REQ*WORD_LEN-1:0] req_data_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic                        rsp_valid_o,
  output logic [NUM_REQ-1:0]          rsp_req_o,
  output logic [WORD_LEN-1:0]         rsp_data_o,
  output logic                        init_done_o,
  output logic                        rf_reset_o,
  output logic                        rf_write_en_o,
  output logic [3:0]                  rf_reg_id_o,
  output logic [WORD_LEN-1:0]         rf_value_o,
  input  logic [WORD_LEN-1:0]         rf_value_i
);
  localparam int unsigned      CNT_W    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_CYCLES - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rf_reset_q, rf_reset_d;
  logic                init_done_q, init_done_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0]  rsp_req_q, rsp_req_d;
  logic [WORD_LEN-1:0] rsp_data_q, rsp_data_d;
  logic [NUM_REQ-1:0]  gnt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_LAST) state_d = ST_RUN;
    end
    rf_reset_d  = (state_d == ST_INIT);
    init_done_d = (state_d == ST_RUN);
  end

`ifdef REGFILE_ARB_RR_EN
  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  logic [PTR_W-1:0] ptr_q, ptr_d;

  // Search starts at the pointer and wraps; the pointer moves past each winner.
  always_comb begin
    int unsigned      idx;
    int unsigned      nxt;
    logic [PTR_W-1:0] sel;
    gnt   = '0;
    ptr_d = ptr_q;
    idx   = 0;
    nxt   = 0;
    sel   = '0;
    if (state_q == ST_RUN) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        idx = 32'(ptr_q) + i;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        sel = PTR_W'(idx);
        if (gnt == '0 && req_valid_i[sel]) begin
          gnt[sel] = 1'b1;
          nxt      = idx + 1;
          if (nxt == NUM_REQ) nxt = 0;
          ptr_d = PTR_W'(nxt);
        end
      end
    end
  end
`else
  always_comb begin
    gnt = '0;
    if (state_q == ST_RUN) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (gnt == '0 && req_valid_i[i]) gnt[i] = 1'b1;
      end
    end
  end
`endif

  // One-hot mux of the winner onto the port; response captures the pre-write read value.
  always_comb begin
    rf_write_en_o = 1'b0;
    rf_reg_id_o   = '0;
    rf_value_o    = '0;
    rsp_valid_d   = |gnt;
    rsp_req_d     = rsp_req_q;
    rsp_data_d    = rsp_data_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        rf_write_en_o = req_write_i[i];
        rf_reg_id_o   = req_reg_i[4*i +: 4];
        rf_value_o    = req_data_i[WORD_LEN*i +: WORD_LEN];
      end
    end
    if (|gnt) begin
      rsp_req_d  = gnt;
      rsp_data_d = rf_value_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      rf_reset_q  <= 1'b1;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_req_q   <= '0;
      rsp_data_q  <= '0;
`ifdef REGFILE_ARB_RR_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rf_reset_q  <= rf_reset_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_req_q   <= rsp_req_d;
      rsp_data_q  <= rsp_data_d;
`ifdef REGFILE_ARB_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign req_ready_o = gnt;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_req_o   = rsp_req_q;
  assign rsp_data_o  = rsp_data_q;
  assign init_done_o = init_done_q;
  assign rf_reset_o  = rf_reset_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed and randomized checks of regfile_arbiter against a transaction-level model.
// A behavioural register file stub answers the DUT port; the model tracks expected contents independently.
module tb_regfile_arbiter;
  localparam int unsigned W    = 64;
  localparam int unsigned N    = 3;
  localparam int unsigned INIT = 2;
  localparam logic [W-1:0] RF_RST = 64'hAAAA_AAAA_AAAA_AAAA;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_ni;
  logic [N-1:0]   req_valid, req_write, req_ready, rsp_req;
  logic [N*4-1:0] req_reg;
  logic [N*W-1:0] req_data;
  logic           rsp_valid, init_done, rf_reset, rf_we;
  logic [W-1:0]   rsp_data, rf_val, rf_rdata;
  logic [3:0]     rf_id;

  regfile_arbiter #(.WORD_LEN(W), .NUM_REQ(N), .INIT_CYCLES(INIT)) dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .req_valid_i(req_valid), .req_write_i(req_write), .req_reg_i(req_reg), .req_data_i(req_data),
    .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_req_o(rsp_req), .rsp_data_o(rsp_data),
    .init_done_o(init_done), .rf_reset_o(rf_reset), .rf_write_en_o(rf_we),
    .rf_reg_id_o(rf_id), .rf_value_o(rf_val), .rf_value_i(rf_rdata)
  );

  // Register file stub: synchronous active-high reset, combinational read.
  logic [W-1:0] stub_mem [16];
  always @(posedge clk) begin
    if (rf_reset) begin
      for (int i = 0; i < 16; i++) stub_mem[i] <= RF_RST;
    end else if (rf_we) begin
      stub_mem[rf_id] <= rf_val;
    end
  end
  assign rf_rdata = stub_mem[rf_id];

  // Reference model state
  logic [W-1:0] m_mem [16];
  logic         m_run;
  int           m_cnt;
  int           m_ptr;
  logic         m_rsp_valid;
  logic [N-1:0] m_rsp_req;
  logic [W-1:0] m_rsp_data;
  logic [N-1:0] last_gnt, obs_gnt;
  int           n_cmp = 0;
  int           n_mis = 0;

  function automatic logic [N-1:0] pick(input logic [N-1:0] v, input int ptr);
    logic [N-1:0] r;
    int start;
    start = ptr;
`ifndef REGFILE_ARB_RR_EN
    start = 0;
`endif
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (v[j]) begin
        r = '0;
        r[j] = 1'b1;
        return r;
      end
    end
    return '0;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic v, input logic wr, input logic [3:0] r, input logic [W-1:0] d);
    req_valid[k]       = v;
    req_write[k]       = wr;
    req_reg[4*k +: 4]  = r;
    req_data[W*k +: W] = d;
  endtask

  // Called at a falling edge with inputs already applied; ends at the next falling edge.
  task automatic tick();
    logic [N-1:0] g;
    int w;
    logic [3:0] r;
    #1;
    g = m_run ? pick(req_valid, m_ptr) : '0;
    obs_gnt = req_ready;
    chk("req_ready", req_ready, g);
    chk("rf_reset", rf_reset, !m_run);
    chk("init_done", init_done, m_run);
    chk("rsp_valid", rsp_valid, m_rsp_valid);
    chk("rsp_req", rsp_req, m_rsp_req);
    chk("rsp_data", rsp_data, m_rsp_data);
    if (g != '0) begin
      w = 0;
      for (int k = 0; k < N; k++) if (g[k]) w = k;
      r = req_reg[4*w +: 4];
      chk("rf_we", rf_we, req_write[w]);
      chk("rf_id", rf_id, r);
      chk("rf_value", rf_val, req_data[W*w +: W]);
      m_rsp_valid = 1'b1;
      m_rsp_req   = g;
      m_rsp_data  = m_mem[r];
      if (req_write[w]) m_mem[r] = req_data[W*w +: W];
      m_ptr = (w + 1) % N;
    end else begin
      chk("idle_we", rf_we, 1'b0);
      chk("idle_id", rf_id, 4'h0);
      chk("idle_value", rf_val, '0);
      m_rsp_valid = 1'b0;
    end
    last_gnt = g;
    if (reset_ni && !m_run) begin
      m_cnt++;
      if (m_cnt >= INIT) m_run = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asserts reset at the current falling edge, holds it for 'cycles', leaves it released.
  task automatic do_reset(input int cycles);
    reset_ni = 1'b0;
    m_run = 1'b0; m_cnt = 0; m_ptr = 0;
    m_rsp_valid = 1'b0; m_rsp_req = '0; m_rsp_data = '0;
    for (int i = 0; i < 16; i++) m_mem[i] = RF_RST;
    #1;
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_rsp_req", rsp_req, '0);
    chk("rst_rf_reset", rf_reset, 1'b1);
    chk("rst_init_done", init_done, 1'b0);
    repeat (cycles) tick();
    reset_ni = 1'b1;
  endtask

  initial begin
    logic [N-1:0] exp_seq [6];
    reset_ni = 1'b1;
    req_valid = '0; req_write = '0; req_reg = '0; req_data = '0;
    @(negedge clk);

    // Init sequence with requester 0 already asking to write REG_A3
    set_req(0, 1'b1, 1'b1, 4'h3, 64'h1234);
    do_reset(3);
    tick();
    tick();
    chk("init_done_c2", init_done, 1'b1);
    chk("rf_reset_c2", rf_reset, 1'b0);
    tick();
    set_req(0, 1'b1, 1'b0, 4'h3, '0);
    chk("wr_swap_data", rsp_data, RF_RST);
    chk("wr_swap_req", rsp_req, 3'b001);
    tick();
    set_req(0, 1'b0, 1'b0, 4'h0, '0);
    chk("rd_data", rsp_data, 64'h1234);
    chk("rd_req", rsp_req, 3'b001);
    chk("rd_valid", rsp_valid, 1'b1);
    tick();

    // Contention
    do_reset(2);
    tick();
    tick();
`ifdef REGFILE_ARB_RR_EN
    exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100;
    exp_seq[3] = 3'b001; exp_seq[4] = 3'b010; exp_seq[5] = 3'b100;
    for (int k = 0; k < 3; k++) set_req(k, 1'b1, 1'b0, 4'(k + 1), '0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_gnt", obs_gnt, exp_seq[i]);
      chk("rr_rsp_req", rsp_req, exp_seq[i]);
    end
`else
    exp_seq[0] = 3'b010; exp_seq[1] = 3'b010; exp_seq[2] = 3'b010;
    exp_seq[3] = 3'b010; exp_seq[4] = 3'b100; exp_seq[5] = 3'b100;
    set_req(1, 1'b1, 1'b0, 4'h1, '0);
    set_req(2, 1'b1, 1'b0, 4'h2, '0);
    for (int i = 0; i < 6; i++) begin
      if (i == 4) set_req(1, 1'b0, 1'b0, 4'h0, '0);
      tick();
      chk("fp_gnt", obs_gnt, exp_seq[i]);
      chk("fp_rsp_req", rsp_req, exp_seq[i]);
    end
`endif

    // Idle: responses hold their last payload
    req_valid = '0;
    repeat (5) tick();
    chk("idle_hold_req", rsp_req, exp_seq[5]);
    chk("idle_hold_valid", rsp_valid, 1'b0);

    // Reset in the cycle after a read grant
    set_req(2, 1'b1, 1'b0, 4'h5, '0);
    tick();
    req_valid = '0;
    chk("mid_pre_valid", rsp_valid, 1'b1);
    chk("mid_pre_data", rsp_data, RF_RST);
    do_reset(1);
    tick();
    chk("mid_reinit", rf_reset, 1'b1);
    tick();

    // Randomized traffic; requesters hold their request until granted
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        do_reset(1 + int'($urandom_range(0, 2)));
      end
      for (int k = 0; k < N; k++) begin
        if (!req_valid[k] && $urandom_range(0, 1) == 1)
          set_req(k, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), {$urandom, $urandom});
      end
      tick();
      req_valid = req_valid & ~last_gnt;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    n_mis++;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $fatal(1, "watchdog expired");
  end

endmodule
